ram_3port_arbiter: RTL and testbench

RAM_3PORT_ARBITER -- requirements
Module: ram_3port_arbiter

---
 rtl/ram_3port_arbiter.sv | 169 ++++++++++++++++
 tb/tb_ram_3port_arbiter.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/ram_3port_arbiter.sv
// Zero-initialising, arbitrating front end for a 1-write / 2-read RAM with
// four read requesters, two write requesters and same-cycle write forwarding.
//   state   | meaning
//   ST_RST  | one cycle after reset, all outputs quiet
//   ST_INIT | writing zero to address r_init_cnt every cycle
//   ST_RUN  | arbitrating read and write requests
module ram_3port_arbiter #(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 64
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      clr,
    output logic                      init_done,
    input  logic [3:0]                rd_req,
    input  logic [4*ADDR_WIDTH-1:0]   rd_addr,
    output logic [3:0]                rd_gnt,
    output logic [3:0]                rd_rsp_valid,
    output logic [4*DATA_WIDTH-1:0]   rd_rsp_data,
    input  logic [1:0]                wr_req,
    input  logic [2*ADDR_WIDTH-1:0]   wr_addr,
    input  logic [2*DATA_WIDTH-1:0]   wr_data,
    output logic [1:0]                wr_gnt,
    output logic                      ram_write_en,
    output logic [ADDR_WIDTH-1:0]     ram_write_addr,
    output logic [DATA_WIDTH-1:0]     ram_write_data,
    output logic [ADDR_WIDTH-1:0]     ram_read_addr1,
    output logic [ADDR_WIDTH-1:0]     ram_read_addr2,
    input  logic [DATA_WIDTH-1:0]     ram_read_data1,
    input  logic [DATA_WIDTH-1:0]     ram_read_data2
);

    typedef enum logic [1:0] {ST_RST, ST_INIT, ST_RUN} state_t;

    state_t                r_state;
    state_t                w_next_state;
    logic [ADDR_WIDTH-1:0] r_init_cnt;
    logic [1:0]            r_rd_ptr;
    logic [1:0]            w_rd_ptr_nxt;
    logic                  r_wr_ptr;
    logic                  w_wr_sel;
    logic                  w_wr_any;
    logic [1:0]            w_port_vld;
    logic [1:0]            w_port_idx [2];
    logic [ADDR_WIDTH-1:0] w_rd_addr_a [4];

    // Per read port: response pending, owning requester, forward flag and data
    logic [1:0]            r_p_vld;
    logic [1:0]            r_p_idx [2];
    logic [1:0]            r_p_fwd;
    logic [DATA_WIDTH-1:0] r_p_fwd_data [2];

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            w_rd_addr_a[i] = rd_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        end
    end

    always_comb begin
        w_next_state   = r_state;
        rd_gnt         = '0;
        wr_gnt         = '0;
        w_port_vld     = '0;
        w_port_idx[0]  = '0;
        w_port_idx[1]  = '0;
        w_rd_ptr_nxt   = r_rd_ptr;
        w_wr_sel       = r_wr_ptr;
        w_wr_any       = 1'b0;
        init_done      = 1'b0;
        ram_write_en   = 1'b0;
        ram_write_addr = '0;
        ram_write_data = '0;
        ram_read_addr1 = '0;
        ram_read_addr2 = '0;
        case (r_state)
            ST_RST: w_next_state = ST_INIT;
            ST_INIT: begin
                ram_write_en   = 1'b1;
                ram_write_addr = r_init_cnt;
                if (!clr && r_init_cnt == '1) w_next_state = ST_RUN;
            end
            ST_RUN: begin
                init_done = 1'b1;
                if (clr) w_next_state = ST_INIT;
                // Rotating scan from r_rd_ptr; first hit takes port 1, second port 2
                for (int k = 0; k < 4; k++) begin
                    logic [1:0] v_idx;
                    v_idx = r_rd_ptr + 2'(k);
                    if (rd_req[v_idx]) begin
                        if (!w_port_vld[0]) begin
                            w_port_vld[0] = 1'b1;
                            w_port_idx[0] = v_idx;
                            rd_gnt[v_idx] = 1'b1;
                            w_rd_ptr_nxt  = v_idx + 2'd1;
                        end else if (!w_port_vld[1]) begin
                            w_port_vld[1] = 1'b1;
                            w_port_idx[1] = v_idx;
                            rd_gnt[v_idx] = 1'b1;
                            w_rd_ptr_nxt  = v_idx + 2'd1;
                        end
                    end
                end
                if (w_port_vld[0]) ram_read_addr1 = w_rd_addr_a[w_port_idx[0]];
                if (w_port_vld[1]) ram_read_addr2 = w_rd_addr_a[w_port_idx[1]];
                if (wr_req[r_wr_ptr]) begin
                    w_wr_sel = r_wr_ptr;
                    w_wr_any = 1'b1;
                end else if (wr_req[~r_wr_ptr]) begin
                    w_wr_sel = ~r_wr_ptr;
                    w_wr_any = 1'b1;
                end
                if (w_wr_any) begin
                    wr_gnt[w_wr_sel] = 1'b1;
                    ram_write_en     = 1'b1;
                    ram_write_addr   = w_wr_sel ? wr_addr[2*ADDR_WIDTH-1:ADDR_WIDTH]
                                                : wr_addr[ADDR_WIDTH-1:0];
                    ram_write_data   = w_wr_sel ? wr_data[2*DATA_WIDTH-1:DATA_WIDTH]
                                                : wr_data[DATA_WIDTH-1:0];
                end
            end
            default: w_next_state = ST_RST;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state         <= ST_RST;
            r_init_cnt      <= '0;
            r_rd_ptr        <= '0;
            r_wr_ptr        <= 1'b0;
            r_p_vld         <= '0;
            r_p_fwd         <= '0;
            r_p_idx[0]      <= '0;
            r_p_idx[1]      <= '0;
            r_p_fwd_data[0] <= '0;
            r_p_fwd_data[1] <= '0;
        end else begin
            r_state <= w_next_state;
            // Wraps to zero after the last address, which is also the RUN value
            if (r_state == ST_INIT && !clr) r_init_cnt <= r_init_cnt + 1'b1;
            else                            r_init_cnt <= '0;
            r_rd_ptr <= w_rd_ptr_nxt;
            if (w_wr_any) r_wr_ptr <= ~w_wr_sel;
            r_p_vld    <= w_port_vld;
            r_p_idx[0] <= w_port_idx[0];
            r_p_idx[1] <= w_port_idx[1];
            r_p_fwd[0] <= w_port_vld[0] && w_wr_any && (ram_read_addr1 == ram_write_addr);
            r_p_fwd[1] <= w_port_vld[1] && w_wr_any && (ram_read_addr2 == ram_write_addr);
            r_p_fwd_data[0] <= ram_write_data;
            r_p_fwd_data[1] <= ram_write_data;
        end
    end

    always_comb begin
        rd_rsp_valid = '0;
        rd_rsp_data  = '0;
        for (int i = 0; i < 4; i++) begin
            if (r_p_vld[0] && r_p_idx[0] == 2'(i)) begin
                rd_rsp_valid[i] = 1'b1;
                rd_rsp_data[i*DATA_WIDTH +: DATA_WIDTH] = r_p_fwd[0] ? r_p_fwd_data[0] : ram_read_data1;
            end
            if (r_p_vld[1] && r_p_idx[1] == 2'(i)) begin
                rd_rsp_valid[i] = 1'b1;
                rd_rsp_data[i*DATA_WIDTH +: DATA_WIDTH] = r_p_fwd[1] ? r_p_fwd_data[1] : ram_read_data2;
            end
        end
    end

endmodule

// File: tb/tb_ram_3port_arbiter.sv
// Bench for ram_3port_arbiter: behavioural RAM plus a list-based reference
// model of init, arbitration, forwarding and responses, checked every cycle.
module tb_ram_3port_arbiter;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         clr;
    logic         init_done;
    logic [3:0]   rd_req;
    logic [23:0]  rd_addr;
    logic [3:0]   rd_gnt;
    logic [3:0]   rd_rsp_valid;
    logic [255:0] rd_rsp_data;
    logic [1:0]   wr_req;
    logic [11:0]  wr_addr;
    logic [127:0] wr_data;
    logic [1:0]   wr_gnt;
    logic         ram_write_en;
    logic [5:0]   ram_write_addr;
    logic [63:0]  ram_write_data;
    logic [5:0]   ram_read_addr1;
    logic [5:0]   ram_read_addr2;
    logic [63:0]  ram_read_data1;
    logic [63:0]  ram_read_data2;

    ram_3port_arbiter dut (
        .clk(clk), .rst_n(rst_n), .clr(clr), .init_done(init_done),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt),
        .rd_rsp_valid(rd_rsp_valid), .rd_rsp_data(rd_rsp_data),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_gnt(wr_gnt),
        .ram_write_en(ram_write_en), .ram_write_addr(ram_write_addr),
        .ram_write_data(ram_write_data), .ram_read_addr1(ram_read_addr1),
        .ram_read_addr2(ram_read_addr2), .ram_read_data1(ram_read_data1),
        .ram_read_data2(ram_read_data2)
    );

    always #5 clk = ~clk;

    // Reference model state; phase 0=RST 1=INIT 2=RUN
    int           m_phase, m_cnt, m_rd_ptr, m_wr_ptr;
    logic [63:0]  m_mem [64];
    logic [3:0]   m_rsp_v;
    logic [255:0] m_rsp_d;
    logic [3:0]   m_rd_gnt;
    logic [1:0]   m_wr_gnt;
    int           checks = 0;
    int           errors = 0;

    // Registered-read RAM; seeded from the model's random contents on the first edge
    logic [63:0]  ram_mem [64];
    bit           seeded;
    always @(posedge clk) begin
        if (!seeded) begin
            for (int i = 0; i < 64; i++) ram_mem[i] <= m_mem[i];
            seeded <= 1'b1;
        end else if (ram_write_en) begin
            ram_mem[ram_write_addr] <= ram_write_data;
        end
        ram_read_data1 <= ram_mem[ram_read_addr1];
        ram_read_data2 <= ram_mem[ram_read_addr2];
    end

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Called just after a negedge with this cycle's inputs applied; returns at the next negedge.
    task automatic cycle();
        logic [3:0]  eg;
        logic [1:0]  ewg;
        int          n, w;
        int          pidx [2];
        logic [5:0]  pa [2];
        logic        ewe;
        logic [5:0]  ewa;
        logic [63:0] ewd;
        #1;
        if (!rst_n) begin
            m_phase = 0; m_cnt = 0; m_rd_ptr = 0; m_wr_ptr = 0;
            m_rsp_v = '0; m_rsp_d = '0;
        end
        eg = '0; ewg = '0; n = 0; w = -1; ewe = 1'b0; ewa = '0; ewd = '0;
        pidx[0] = 0; pidx[1] = 0; pa[0] = '0; pa[1] = '0;
        if (m_phase == 1) begin
            ewe = 1'b1;
            ewa = m_cnt[5:0];
        end
        if (m_phase == 2) begin
            for (int k = 0; k < 4; k++) begin
                int idx;
                idx = (m_rd_ptr + k) % 4;
                if (rd_req[idx] && n < 2) begin
                    eg[idx] = 1'b1;
                    pidx[n] = idx;
                    pa[n]   = rd_addr[idx*6 +: 6];
                    n++;
                end
            end
            if (wr_req[m_wr_ptr])          w = m_wr_ptr;
            else if (wr_req[1 - m_wr_ptr]) w = 1 - m_wr_ptr;
            if (w >= 0) begin
                ewg[w] = 1'b1;
                ewe    = 1'b1;
                ewa    = wr_addr[w*6 +: 6];
                ewd    = wr_data[w*64 +: 64];
            end
        end
        chk("init_done", init_done, (m_phase == 2));
        chk("rd_gnt", rd_gnt, eg);
        chk("wr_gnt", wr_gnt, ewg);
        chk("ram_we", ram_write_en, ewe);
        chk("ram_waddr", ram_write_addr, ewa);
        chk("ram_wdata", ram_write_data, ewd);
        chk("ram_raddr1", ram_read_addr1, pa[0]);
        chk("ram_raddr2", ram_read_addr2, pa[1]);
        chk("rsp_valid", rd_rsp_valid, m_rsp_v);
        chk("rsp_data", rd_rsp_data, m_rsp_d);
        m_rd_gnt = eg;
        m_wr_gnt = ewg;
        if (rst_n) begin
            m_rsp_v = eg;
            m_rsp_d = '0;
            for (int j = 0; j < n; j++)
                m_rsp_d[pidx[j]*64 +: 64] = (w >= 0 && ewa == pa[j]) ? ewd : m_mem[pa[j]];
            if (ewe) m_mem[ewa] = ewd;
            if (n > 0)  m_rd_ptr = (pidx[n-1] + 1) % 4;
            if (w >= 0) m_wr_ptr = 1 - w;
            case (m_phase)
                0: begin m_phase = 1; m_cnt = 0; end
                1: begin
                    if (clr)              m_cnt = 0;
                    else if (m_cnt == 63) begin m_phase = 2; m_cnt = 0; end
                    else                  m_cnt++;
                end
                default: if (clr) begin m_phase = 1; m_cnt = 0; end
            endcase
        end
        @(negedge clk);
    endtask

    task automatic idle();
        rd_req = '0; wr_req = '0; clr = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 64; i++) m_mem[i] = {$urandom, $urandom};
        m_phase = 0; m_cnt = 0; m_rd_ptr = 0; m_wr_ptr = 0;
        m_rsp_v = '0; m_rsp_d = '0; m_rd_gnt = '0; m_wr_gnt = '0;
        rst_n = 1'b0; clr = 1'b0; rd_req = '0; rd_addr = '0;
        wr_req = '0; wr_addr = '0; wr_data = '0;
        @(negedge clk);
        cycle(); cycle();
        rst_n = 1'b1;
        repeat (66) cycle();

        // Every address reads back zero after init
        for (int a = 0; a < 64; a++) begin
            rd_req = '0;
            rd_req[a % 4] = 1'b1;
            rd_addr[(a % 4)*6 +: 6] = a[5:0];
            cycle();
        end
        idle(); cycle();

        // All four readers held
        rd_req = 4'hF;
        rd_addr = {6'd33, 6'd22, 6'd11, 6'd0};
        repeat (3) cycle();
        idle(); cycle();

        // Both writers held, then read back
        wr_req = 2'b11;
        wr_addr = {6'd20, 6'd10};
        wr_data = {64'h2222_3333_4444_5555, 64'h1111_AAAA_BBBB_CCCC};
        repeat (3) cycle();
        idle();
        rd_req = 4'b0011;
        rd_addr = {12'd0, 6'd20, 6'd10};
        cycle();
        idle(); cycle();

        // Same-cycle write/read to address 5
        wr_req = 2'b01; wr_addr = {6'd0, 6'd5}; wr_data = {64'd0, 64'hA5};
        rd_req = 4'b0100; rd_addr = {6'd0, 6'd5, 12'd0};
        cycle();
        idle(); cycle();

        // clr in RUN with a pending read
        rd_req = 4'b0001; rd_addr = {18'd0, 6'd10}; clr = 1'b1;
        cycle();
        idle();
        repeat (66) cycle();

        // Randomised traffic, requests held until the model grants them
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < 4; i++) begin
                if (!rd_req[i] || m_rd_gnt[i]) begin
                    rd_req[i] = ($urandom_range(0, 99) < 55);
                    rd_addr[i*6 +: 6] = $urandom_range(0, 1) ? 6'($urandom_range(0, 7))
                                                             : 6'($urandom_range(0, 63));
                end
            end
            for (int j = 0; j < 2; j++) begin
                if (!wr_req[j] || m_wr_gnt[j]) begin
                    wr_req[j] = ($urandom_range(0, 99) < 45);
                    wr_addr[j*6 +: 6] = $urandom_range(0, 1) ? 6'($urandom_range(0, 7))
                                                             : 6'($urandom_range(0, 63));
                    wr_data[j*64 +: 64] = {$urandom, $urandom};
                end
            end
            clr = ($urandom_range(0, 399) == 0);
            cycle();
        end
        idle();
        repeat (70) cycle();

        // Reset in the middle of INIT
        clr = 1'b1; cycle(); clr = 1'b0;
        repeat (30) cycle();
        rst_n = 1'b0;
        cycle(); cycle();
        rst_n = 1'b1;
        repeat (70) cycle();
        for (int a = 0; a < 8; a++) begin
            rd_req = 4'b1000;
            rd_addr = {6'(a * 7), 18'd0};
            cycle();
        end
        idle(); cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
